// File: rtl/row_projector.sv
// -----------------------------------------------------------------------------
// row_projector
//
// Streaming column-window projection stage. It consumes row beats from the
// fetch unit, keeps the contiguous window of C words starting at column F of
// every R-word row, and emits those words on a single registered output stage.
// The block counts words and rows, pulses done when a job has fully drained,
// and raises a sticky error for a bad configuration or an s_last framing
// mismatch.
//
// Ports
//   ACLK, ARESETN      clock, synchronous active-low reset
//   cfg_start          one-cycle job start pulse (ignored while busy)
//   cfg_row_words      R, words per row
//   cfg_col_first      F, first kept column
//   cfg_col_words      C, kept columns per row
//   cfg_num_rows       N, rows in the job
//   s_data/s_valid/s_last/s_ready   input beat stream
//   m_data/m_valid/m_last/m_ready   projected output stream
//   busy, done, error  job status
//   dbg_state          current FSM state (IDLE=0, RUN=1, FLUSH=2)
//
// Handshake: on both streams a word transfers on a rising edge where
// valid && ready are both 1. A producer holds valid and payload stable until
// the transfer; ready may depend combinationally on the consumer's state and
// on m_ready, but never on s_valid.
// -----------------------------------------------------------------------------
module row_projector #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_W      = 8,
   parameter int NROW_W     = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_start,
   input  logic [ROW_W-1:0]      cfg_row_words,
   input  logic [ROW_W-1:0]      cfg_col_first,
   input  logic [ROW_W-1:0]      cfg_col_words,
   input  logic [NROW_W-1:0]     cfg_num_rows,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            dbg_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]            state_q,    state_d;
   logic [ROW_W-1:0]      r_q,        r_d;
   logic [ROW_W-1:0]      f_q,        f_d;
   logic [ROW_W-1:0]      c_q,        c_d;
   logic [NROW_W-1:0]     n_q,        n_d;
   logic [ROW_W-1:0]      word_idx_q, word_idx_d;
   logic [NROW_W-1:0]     row_idx_q,  row_idx_d;
   logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
   logic                  m_valid_q,  m_valid_d;
   logic                  m_last_q,   m_last_d;
   logic                  done_q,     done_d;
   logic                  error_q,    error_d;

   logic                  accept;
   logic                  keep;
   logic                  last_row;
   logic                  row_end;
   logic                  final_beat;
   logic                  cfg_bad;
   logic [ROW_W:0]        win_end;     // F+C, one bit wider so it cannot wrap
   logic [ROW_W:0]        cfg_win_end;
   logic [ROW_W:0]        word_ext;

   // Dropped beats also wait for the output register to be free; this keeps
   // s_ready independent of the current word's column position.
   assign s_ready    = (state_q == ST_RUN) && (!m_valid_q || m_ready);
   assign accept     = s_valid && s_ready;

   assign win_end    = {1'b0, f_q} + {1'b0, c_q};
   assign word_ext   = {1'b0, word_idx_q};
   assign keep       = (word_ext >= {1'b0, f_q}) && (word_ext < win_end);
   assign row_end    = (word_idx_q == r_q - 1'b1);
   assign last_row   = (row_idx_q == n_q - 1'b1);
   assign final_beat = row_end && last_row;

   assign cfg_win_end = {1'b0, cfg_col_first} + {1'b0, cfg_col_words};
   assign cfg_bad     = (cfg_row_words == '0) || (cfg_col_words == '0) ||
                        (cfg_num_rows == '0) ||
                        (cfg_win_end > {1'b0, cfg_row_words});

   always_comb begin
      state_d    = state_q;
      r_d        = r_q;
      f_d        = f_q;
      c_d        = c_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      row_idx_d  = row_idx_q;
      m_data_d   = m_data_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      done_d     = 1'b0;
      error_d    = error_q;

      // Output register: a forwarded beat reloads it (no bubble even when the
      // current word is handed off on the same edge); otherwise it empties
      // once downstream takes the word.
      if (accept && keep) begin
         m_data_d  = s_data;
         m_valid_d = 1'b1;
         m_last_d  = last_row && (word_ext == win_end - 1'b1);
      end else if (m_ready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               r_d        = cfg_row_words;
               f_d        = cfg_col_first;
               c_d        = cfg_col_words;
               n_d        = cfg_num_rows;
               word_idx_d = '0;
               row_idx_d  = '0;
               if (cfg_bad) begin
                  error_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  error_d = 1'b0;
                  state_d = ST_RUN;
               end
            end
         end

         ST_RUN: begin
            if (accept) begin
               if (s_last != final_beat) begin
                  error_d = 1'b1;
               end
               if (row_end) begin
                  word_idx_d = '0;
                  row_idx_d  = final_beat ? '0 : row_idx_q + 1'b1;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
               // Accept implies the register is empty after this edge unless
               // the final beat itself was forwarded, so only that case has
               // anything left to drain.
               if (final_beat) begin
                  if (keep) begin
                     state_d = ST_FLUSH;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end

         ST_FLUSH: begin
            if (m_valid_q && m_ready) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         r_q        <= '0;
         f_q        <= '0;
         c_q        <= '0;
         n_q        <= '0;
         word_idx_q <= '0;
         row_idx_q  <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_q        <= r_d;
         f_q        <= f_d;
         c_q        <= c_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         row_idx_q  <= row_idx_d;
         m_data_q   <= m_data_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_row_projector.sv
module tb_row_projector;

   logic        ACLK;
   logic        ARESETN;
   logic        cfg_start;
   logic [7:0]  cfg_row_words;
   logic [7:0]  cfg_col_first;
   logic [7:0]  cfg_col_words;
   logic [15:0] cfg_num_rows;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_last;
   logic        m_ready;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  dbg_state;

   row_projector #(.DATA_WIDTH(32), .ROW_W(8), .NROW_W(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start),
      .cfg_row_words(cfg_row_words), .cfg_col_first(cfg_col_first),
      .cfg_col_words(cfg_col_words), .cfg_num_rows(cfg_num_rows),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   bit          exp_last_q[$];
   int          acc_cyc_q[$];
   logic [31:0] data_a[$];
   int          done_cnt = 0;
   bit          chk_lat = 0;
   int          ready_mode = 0;  // 0: always 1, 1: 1,0,0,1 pattern, 2: random
   int          rdy_step = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Downstream ready generator, changes just after each rising edge.
   always @(posedge ACLK) begin
      #1;
      rdy_step++;
      case (ready_mode)
         0: m_ready = 1'b1;
         1: m_ready = ((rdy_step % 4) == 0) || ((rdy_step % 4) == 3);
         default: m_ready = ($urandom_range(0, 99) < 60);
      endcase
   end

   // Output monitor: sampled mid-cycle, away from the active edge.
   bit          stall_prev = 0;
   logic [31:0] prev_data;
   logic        prev_last;
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         stall_prev = 0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
         end
         if (m_valid && !m_ready) chk("sready_stall", {31'd0, s_ready}, 32'd0);
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", m_data, 32'hdead_beef);
            end else begin
               chk("m_data", m_data, exp_q.pop_front());
               chk("m_last", {31'd0, m_last}, {31'd0, exp_last_q.pop_front()});
            end
            if (chk_lat && acc_cyc_q.size() > 0)
               chk("latency", cyc, acc_cyc_q.pop_front() + 1);
         end
         if (done) done_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      ARESETN = 1'b0; cfg_start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      repeat (3) @(posedge ACLK);
      #1 ARESETN = 1'b1;
      @(negedge ACLK);
      chk("rst_outs", {m_data[27:0], m_valid, m_last, s_ready, busy},
          32'd0);
      chk("rst_status", {28'd0, done, error, dbg_state}, 32'd0);
   endtask

   // Reference model: walk the job as an R x N grid of words and keep the
   // window columns; the last kept word of the last row carries m_last.
   task automatic build_expected(input int r, input int f, input int c, input int n);
      for (int i = 0; i < r * n; i++) begin
         int w = i % r;
         int row = i / r;
         if (w >= f && w < f + c) begin
            exp_q.push_back(data_a[i]);
            exp_last_q.push_back((row == n - 1) && (w == f + c - 1));
         end
      end
   endtask

   task automatic fill_seq(input int count);
      data_a.delete();
      for (int i = 0; i < count; i++) data_a.push_back(32'(i + 1));
   endtask

   task automatic fill_rand(input int count);
      data_a.delete();
      for (int i = 0; i < count; i++) data_a.push_back($urandom);
   endtask

   // bad_beat: 1-based beat that also carries s_last (0 = none).
   // drop_last: omit s_last on the final beat. abort_after: reset after
   // that many accepted beats (0 = run to completion).
   task automatic run_job(input int r, input int f, input int c, input int n,
                          input int bad_beat, input bit drop_last,
                          input int abort_after, input int gap_pct, input bit lat);
      int  total = r * n;
      int  tries = 0;
      bit  timed_out = 0;
      exp_q.delete(); exp_last_q.delete(); acc_cyc_q.delete();
      build_expected(r, f, c, n);
      done_cnt = 0;
      chk_lat  = lat;
      @(posedge ACLK); #1;
      cfg_row_words = 8'(r); cfg_col_first = 8'(f);
      cfg_col_words = 8'(c); cfg_num_rows = 16'(n);
      cfg_start = 1'b1;
      @(posedge ACLK); #1;
      cfg_start = 1'b0;
      @(negedge ACLK);
      chk("start_busy_err", {30'd0, busy, error}, 32'd2);
      @(posedge ACLK); #1;
      for (int i = 0; i < total && !timed_out; i++) begin
         bit acc = 0;
         int budget = 0;
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge ACLK); #1;
         end
         s_valid = 1'b1;
         s_data  = data_a[i];
         s_last  = ((i == total - 1) && !drop_last) || (i + 1 == bad_beat);
         while (!acc) begin
            @(negedge ACLK);
            acc = s_ready;
            tries++;
            if (acc && lat) acc_cyc_q.push_back(cyc);
            @(posedge ACLK); #1;
            budget++;
            if (!acc && budget > 200) begin
               chk("accept_timeout", 32'd0, 32'd1);
               timed_out = 1;
               break;
            end
         end
         s_valid = 1'b0; s_last = 1'b0;
         if (acc && i + 1 == bad_beat) begin
            @(negedge ACLK);
            chk("framing_err", {31'd0, error}, 32'd1);
            @(posedge ACLK); #1;
         end
         if (acc && i + 1 == abort_after) begin
            ARESETN = 1'b0;
            @(posedge ACLK); #1;
            ARESETN = 1'b1;
            @(negedge ACLK);
            chk("abort_outs", {m_data[27:0], m_valid, m_last, s_ready, busy}, 32'd0);
            chk("abort_status", {28'd0, done, error, dbg_state}, 32'd0);
            exp_q.delete(); exp_last_q.delete(); acc_cyc_q.delete();
            repeat (6) @(posedge ACLK);
            #2 chk("abort_no_done", done_cnt, 0);
            return;
         end
      end
      if (lat) chk("throughput_tries", tries, total);
      for (int k = 0; k < 400 && done_cnt == 0; k++) begin
         @(posedge ACLK); #2;
      end
      repeat (4) @(posedge ACLK);
      #2;
      chk("done_count", done_cnt, 1);
      chk("exp_drained", exp_q.size(), 0);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_error", {31'd0, error}, {31'd0, (bad_beat != 0) || drop_last});
      chk_lat = 0;
   endtask

   task automatic bad_cfg(input int r, input int f, input int c, input int n);
      @(posedge ACLK); #1;
      cfg_row_words = 8'(r); cfg_col_first = 8'(f);
      cfg_col_words = 8'(c); cfg_num_rows = 16'(n);
      cfg_start = 1'b1;
      @(posedge ACLK); #1;
      cfg_start = 1'b0;
      @(negedge ACLK);
      chk("badcfg_pulse", {28'd0, done, error, busy, s_ready}, 32'b1100);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("badcfg_after", {28'd0, done, error, busy, s_ready}, 32'b0100);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      cfg_row_words = '0; cfg_col_first = '0; cfg_col_words = '0; cfg_num_rows = '0;
      m_ready = 1'b1;
      do_reset();

      // Basic projection: expect 2,3,6,7,10,11
      ready_mode = 0;
      fill_seq(12);
      run_job(4, 1, 2, 3, 0, 0, 0, 0, 0);

      // Backpressure with the 1,0,0,1 pattern, then random
      ready_mode = 1;
      run_job(4, 1, 2, 3, 0, 0, 0, 0, 0);
      ready_mode = 2;
      run_job(4, 1, 2, 3, 0, 0, 0, 25, 0);

      // Full row: pure one-cycle register slice
      ready_mode = 0;
      fill_seq(8);
      run_job(8, 0, 8, 1, 0, 0, 0, 0, 1);

      // Bad configurations, then a valid job clears error
      bad_cfg(4, 3, 2, 1);
      bad_cfg(0, 0, 1, 1);
      bad_cfg(4, 0, 0, 1);
      bad_cfg(4, 0, 2, 0);
      fill_seq(12);
      run_job(4, 1, 2, 3, 0, 0, 0, 0, 0);

      // Framing: early s_last on beat 8, and missing final s_last
      run_job(4, 1, 2, 3, 8, 0, 0, 0, 0);
      run_job(4, 1, 2, 3, 0, 1, 0, 0, 0);

      // Reset after beat 5, then a fresh basic job
      run_job(4, 1, 2, 3, 0, 0, 5, 0, 0);
      run_job(4, 1, 2, 3, 0, 0, 0, 0, 0);

      // Window ending before the row end (final beat dropped, no flush)
      fill_seq(6);
      run_job(3, 0, 1, 2, 0, 0, 0, 0, 0);

      // Randomised jobs
      for (int j = 0; j < 10; j++) begin
         int r = $urandom_range(1, 8);
         int c = $urandom_range(1, r);
         int f = $urandom_range(0, r - c);
         int n = $urandom_range(1, 4);
         ready_mode = $urandom_range(0, 2);
         fill_rand(r * n);
         run_job(r, f, c, n, 0, 0, 0, $urandom_range(0, 40), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/row_projector.md
# row_projector

Streaming projection stage directly downstream of the fetch unit's AXI read path. It consumes the 32-bit row beats that the fetch unit pulls from DRAM and keeps only the contiguous column window selected by configuration. The kept words are emitted as a packed stream to the relational-memory output buffer. The block also counts rows and words, reports completion, and flags framing mismatches against the fetch unit's end-of-transfer marker.

## Interface
- DATA_WIDTH, 32, beat width in bits (input and output)
- ROW_W, 8, width of the row-length and column-index fields
- NROW_W, 16, width of the row-count field
- ACLK  in  1  clock; all logic is rising-edge
- ARESETN  in  1  reset; synchronous, active-low
- cfg_start  in  1  one-cycle pulse that latches cfg_* and starts a job; ignored while busy
- cfg_row_words  in  ROW_W  words per row (R)
- cfg_col_first  in  ROW_W  index of the first kept word in each row (F)
- cfg_col_words  in  ROW_W  number of kept words per row (C)
- cfg_num_rows  in  NROW_W  rows in the job (N)
- s_data  in  DATA_WIDTH  row beat from the fetch unit
- s_valid  in  1  s_data valid
- s_last  in  1  fetch unit marks its final beat
- s_ready  out  1  beat accepted when s_valid && s_ready
- m_data  out  DATA_WIDTH  projected word
- m_valid  out  1  m_data valid
- m_last  out  1  final projected word of the job
- m_ready  in  1  downstream accepts when m_valid && m_ready
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky status; cleared on the next accepted cfg_start

## Operation
- Reset (ARESETN=0 at an edge): state=IDLE; all counters 0; s_ready, m_valid, m_last, busy, done and error all 0. m_data is 0.
- States:
  - IDLE: on cfg_start, latch R, F, C and N, clear error, then either go to RUN or reject the configuration.
  - Bad configuration is R==0, C==0, N==0, or F+C>R, with the sum computed at ROW_W+1 bits.
  - Rejected configuration: set error, pulse done, stay in IDLE, and do not assert busy.
  - RUN: accept beats, project them, and count them.
  - FLUSH: wait for the final output word to be accepted, pulse done, then go to IDLE.
- Counters:
  - word_idx runs 0..R-1 and wraps to 0 at the end of each row.
  - row_idx runs 0..N-1.
- Projection: an accepted beat is forwarded iff F <= word_idx < F+C. Any other accepted beat is consumed and dropped.
- Job end: the final input beat is word_idx==R-1 with row_idx==N-1. After it, the block enters FLUSH, or goes straight to IDLE with a done pulse if the output register is empty.
- m_last is set on the forwarded word where word_idx==F+C-1 and row_idx==N-1.
- Framing check:
  - s_last==1 on any beat other than the final input beat sets error; the block continues counting.
  - s_last==0 on the final input beat sets error.
  - Either way, the job still completes by count and done pulses. error stays 1 until the next accepted cfg_start.
- busy = state!=IDLE.
- cfg_start while busy has no effect.

## Timing
- Output is a single registered stage.
- s_ready = (state==RUN) && (!m_valid || m_ready). The same rule applies to dropped beats, which keeps the logic simple.
- Latency: a beat accepted at edge k appears on m_data/m_valid after edge k, in cycle k+1.
- Throughput is 1 beat/cycle when m_ready is held at 1.
- m_valid, m_data and m_last hold stable while m_valid && !m_ready.
- m_valid drops after the accepting edge unless a new forwarded beat is loaded on that same edge.
- done asserts for exactly one cycle, in the cycle after the edge where the final output word is accepted. If the job produced no pending output, done asserts in the cycle after the final input beat is accepted.
- Simultaneous m_ready handshake and new forwarded beat: the register is reloaded with no bubble.
- Reset asserted mid-job: all state returns to reset values at that edge. The in-flight output word is discarded and no done pulse is generated.
- Full-row projection (F=0, C=R): every beat is forwarded and the block behaves as a pure 1-cycle register slice.

## Test plan
- Basic projection:
  - Stimulus: R=4, F=1, C=2, N=3; s_data=1..12 with s_last on 12; m_ready=1.
  - Required: m_data sequence 2,3,6,7,10,11; m_last only with 11; done pulses once; error=0.
- Backpressure:
  - Stimulus: same job with m_ready toggling 1,0,0,1,…
  - Required: identical output sequence; m_data is stable while stalled; no beat is lost or duplicated; s_ready is 0 whenever m_valid && !m_ready.
- Full row:
  - Stimulus: R=8, F=0, C=8, N=1; data 1..8.
  - Required: output 1..8 at 1 word/cycle; first m_valid one cycle after the first accept; m_last with 8.
- Bad configuration:
  - Stimulus: R=4, F=3, C=2.
  - Required: error=1, done pulses one cycle after cfg_start, busy stays 0, s_ready stays 0.
  - Follow-up: a subsequent valid cfg_start clears error.
- Framing mismatch:
  - Stimulus: the basic job with s_last asserted on beat 8.
  - Required: error=1 from the cycle after beat 8; output and done are unchanged from the basic case.
- Reset mid-job:
  - Stimulus: ARESETN=0 for one edge after beat 5 of the basic job.
  - Required: all outputs return to 0, no done pulse, and a fresh job afterwards produces 2,3,6,7,10,11.
